bcd_serial_addsub_ctrl: RTL

//   Digit-serial BCD add/subtract engine for wide decimal operands. One
//   bcd_fadd digit slice is shared across all digit positions and sequenced
//   LSD-first, one digit per clock. It is the area-cheap alternative to the

---
 rtl/bcd_serial_addsub_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bcd_serial_addsub_ctrl.sv
// bcd_serial_addsub_ctrl
//   Digit-serial BCD add/subtract engine. A single BCD digit slice is reused
//   for every digit position. Digits are processed least significant first,
//   one per clock. Subtraction is A + (9's complement of B) + 1, which gives
//   the ten's complement result. No sign correction is applied.
//
//   Handshakes: a transfer happens on a rising edge where valid && ready are
//   both high. start_ready is high only in IDLE. The operands are captured
//   on the accept edge and may change freely after that. res_valid stays
//   high, with sum/cout/err held stable, until the edge where res_ready is
//   also high.
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   start_valid/start_ready  operation request handshake
//   a, b                     operands, digit i at [4i+3:4i]
//   cin                      carry in (ignored when sub=1)
//   sub                      0: A+B+cin, 1: A-B
//   abort                    cancels a running operation (RUN state only)
//   busy                     engine not idle
//   res_valid/res_ready      result handshake
//   sum, cout, err           BCD result, final carry (no-borrow in sub mode),
//                            invalid-digit flag for this operation
module bcd_serial_addsub_ctrl #(
   parameter int DIGITS = 100,
   parameter int IDX_W  = 7
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_valid,
   output logic                start_ready,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   input  logic                cin,
   input  logic                sub,
   input  logic                abort,
   output logic                busy,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [4*DIGITS-1:0] sum,
   output logic                cout,
   output logic                err
);

   localparam int               W        = 4 * DIGITS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx;
   logic             carry;
   logic [W-1:0]     a_q, b_q, sum_q;
   logic             sub_q, cout_q, err_q;

   logic             last;
   logic [3:0]       a_dig, b_dig, bd, digit;
   logic [4:0]       t, t_adj;
   logic             c_new;

   assign start_ready = (state == IDLE);
   assign busy        = (state != IDLE);
   assign res_valid   = (state == HOLD);
   assign sum         = sum_q;
   assign cout        = cout_q;
   assign err         = err_q;
   assign last        = (idx == LAST_IDX);

   // Select the current digit of each latched operand.
   always_comb begin
      a_dig = '0;
      b_dig = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            a_dig = a_q[4*i +: 4];
            b_dig = b_q[4*i +: 4];
         end
      end
   end

   // Shared BCD digit slice. The maximum t is 15+15+1, so it fits in 5 bits
   // even when the input digits are invalid.
   always_comb begin
      bd    = sub_q ? (4'd9 - b_dig) : b_dig;
      t     = {1'b0, a_dig} + {1'b0, bd} + {4'b0, carry};
      t_adj = t + 5'd6;
      c_new = (t > 5'd9);
      digit = c_new ? t_adj[3:0] : t[3:0];
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next state; abort wins over completion of the last digit.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start_valid) state_nxt = RUN;
         RUN: begin
            if (abort)     state_nxt = IDLE;
            else if (last) state_nxt = HOLD;
         end
         HOLD:    if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         sub_q  <= 1'b0;
         idx    <= '0;
         carry  <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  sub_q <= sub;
                  carry <= sub ? 1'b1 : cin;
                  idx   <= '0;
                  err_q <= 1'b0;
                  sum_q <= '0;
               end
            end
            RUN: begin
               if (!abort) begin
                  for (int i = 0; i < DIGITS; i++) begin
                     if (idx == IDX_W'(i)) sum_q[4*i +: 4] <= digit;
                  end
                  carry <= c_new;
                  idx   <= idx + 1'b1;
                  err_q <= err_q | (a_dig > 4'd9) | (b_dig > 4'd9);
                  if (last) cout_q <= c_new;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
